// File: rtl/mandel_param_rx_pkg.sv
// mandel_param_rx_pkg: shared Q4.12 widths, reset-default parameter set and FSM encoding
package mandel_param_rx_pkg;
    localparam int BIT_INT   = 4;
    localparam int BIT_FRAC  = 12;
    localparam int N_BIT     = BIT_INT + BIT_FRAC;
    localparam int N_PAYLOAD = 10;

    // Field order matches payload byte order, so the shadow shift register casts directly.
    typedef struct packed {
        logic [7:0]       pix_x;
        logic [7:0]       pix_y;
        logic [N_BIT-1:0] cxs;
        logic [N_BIT-1:0] cys;
        logic [N_BIT-1:0] dcx;
        logic [N_BIT-1:0] dcy;
    } params_t;

    localparam params_t PARAM_RST = '{
        pix_x: 8'hFF, pix_y: 8'hFF,
        cxs: 16'hE000, cys: 16'hF000,
        dcx: 16'h0020, dcy: 16'h0020
    };

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_PENDING} state_e;
endpackage

// File: rtl/mandel_param_rx_if.sv
// mandel_param_rx_if: UART byte input, engine status and parameter-set outputs
interface mandel_param_rx_if;
    import mandel_param_rx_pkg::*;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             engine_busy;
    logic [7:0]       pix_x;
    logic [7:0]       pix_y;
    logic [N_BIT-1:0] cxs;
    logic [N_BIT-1:0] cys;
    logic [N_BIT-1:0] dcx;
    logic [N_BIT-1:0] dcy;
    logic             start;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  r_data, r_ready, engine_busy,
        output pix_x, pix_y, cxs, cys, dcx, dcy, start, frame_err, busy
    );
    modport master (
        output r_data, r_ready, engine_busy,
        input  pix_x, pix_y, cxs, cys, dcx, dcy, start, frame_err, busy
    );
endinterface

// File: rtl/mandel_byte_edge.sv
// mandel_byte_edge: one accept pulse on each rising edge of the r_ready level
module mandel_byte_edge (
    input  logic clk,
    input  logic rst,
    input  logic r_ready_i,
    output logic accept_o
);
    logic rdy_q;

    // Cleared in reset so a level held across reset release still yields one accept.
    always_ff @(posedge clk) rdy_q <= rst ? 1'b0 : r_ready_i;

    assign accept_o = r_ready_i & ~rdy_q & ~rst;
endmodule

// File: rtl/mandel_param_rx.sv
// mandel_param_rx: framed UART parameter receiver with checksum, timeout and engine-busy hold-off
module mandel_param_rx
    import mandel_param_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 70000
) (
    input logic              clk,
    input logic              rst,
    mandel_param_rx_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [7:0]             xor_q, xor_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [8*N_PAYLOAD-1:0] shadow_q, shadow_d;
    params_t                par_q, par_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   accept, timeout, load;

    mandel_byte_edge u_edge (
        .clk       (clk),
        .rst       (rst),
        .r_ready_i (bus.r_ready),
        .accept_o  (accept)
    );

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = !accept && gap_q == GW'(TIMEOUT_CYCLES - 1);
    assign par_d   = load ? params_t'(shadow_q) : par_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        shadow_d = shadow_q;
        gap_d    = '0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && bus.r_data == SYNC_BYTE) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            S_PAYLOAD, S_CHECK: begin
                gap_d = accept ? '0 : gap_q + 1'b1;
                if (accept && state_q == S_PAYLOAD) begin
                    shadow_d = {shadow_q[8*N_PAYLOAD-9:0], bus.r_data};
                    xor_d    = xor_q ^ bus.r_data;
                    idx_d    = idx_q + 1'b1;
                    state_d  = idx_q == 4'(N_PAYLOAD - 1) ? S_CHECK : S_PAYLOAD;
                end else if (accept) begin
                    state_d = bus.r_data == xor_q && bus.engine_busy ? S_PENDING : S_IDLE;
                    err_d   = bus.r_data != xor_q;
                    load    = bus.r_data == xor_q && !bus.engine_busy;
                    start_d = load;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    gap_d   = '0;
                end
            end
            S_PENDING: begin
                // Release takes priority so start and frame_err never coincide.
                load    = !bus.engine_busy;
                start_d = load;
                err_d   = accept && bus.engine_busy;
                state_d = load ? S_IDLE : S_PENDING;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            xor_q    <= '0;
            gap_q    <= '0;
            shadow_q <= '0;
            par_q    <= PARAM_RST;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

    assign bus.pix_x     = par_q.pix_x;
    assign bus.pix_y     = par_q.pix_y;
    assign bus.cxs       = par_q.cxs;
    assign bus.cys       = par_q.cys;
    assign bus.dcx       = par_q.dcx;
    assign bus.dcy       = par_q.dcy;
    assign bus.start     = start_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = state_q != S_IDLE;
endmodule

// File: doc/mandel_param_rx.md
MANDEL_PARAM_RX -- requirements
Module: mandel_param_rx

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, frame header byte.
REQ-002 Parameter: TIMEOUT_CYCLES, 70000, maximum clk cycles allowed between accepted bytes of one frame (1 ms at 70 MHz).
REQ-003 Port: clk  input  1  system clock; the main compute clock.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: r_data  input  8  received UART byte; valid while r_ready is high.
REQ-006 Port: r_ready  input  1  level, high for one or more cycles per received byte.
REQ-007 Port: engine_busy  input  1  downstream Mandelbrot engine is still rendering.
REQ-008 Port: pix_x, pix_y  output  8 each  frame size in pixels.
REQ-009 Port: cxs, cys, dcx, dcy  output  16 each  start point and step, Q4.12 two's complement.
REQ-010 Port: start  output  1  one-cycle pulse; new parameter set is valid.
REQ-011 Port: frame_err  output  1  one-cycle pulse on a checksum error, timeout or dropped byte.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 Byte accept: a byte is accepted in the cycle where r_ready=1 and the registered r_ready from the previous cycle =0; exactly one accept per r_ready high period.
REQ-014 Frame format: SYNC_BYTE, then 10 payload bytes, then 1 checksum byte; the checksum is the XOR of the 10 payload bytes.
REQ-015 Payload order: pix_x, pix_y, cxs[15:8], cxs[7:0], cys[15:8], cys[7:0], dcx[15:8], dcx[7:0], dcy[15:8], dcy[7:0].
REQ-016 States: IDLE, PAYLOAD, CHECK, PENDING.
REQ-017 IDLE: an accepted byte equal to SYNC_BYTE goes to PAYLOAD with the byte index cleared to 0; any other byte is discarded silently.
REQ-018 PAYLOAD: each accepted byte goes into a shadow register at the byte index and updates the running XOR; after index 9 the state goes to CHECK. SYNC_BYTE values are ordinary data here.
REQ-019 CHECK, checksum match with engine_busy=0: the shadow registers are copied to the outputs and start=1 in the next cycle; the state returns to IDLE.
REQ-020 CHECK, checksum match with engine_busy=1: the state goes to PENDING and the outputs are left unchanged.
REQ-021 CHECK, checksum mismatch: frame_err=1 in the next cycle, the state returns to IDLE and the outputs are left unchanged.
REQ-022 PENDING: in the first cycle engine_busy=0, the outputs are updated and start=1 in the next cycle, and the state goes to IDLE; bytes accepted while PENDING are dropped and each one pulses frame_err.
REQ-023 Timeout: in PAYLOAD or CHECK, a gap counter counts cycles since the last accepted byte; at TIMEOUT_CYCLES the state goes to IDLE, frame_err pulses and the shadow registers are discarded.
REQ-024 Byte accept and timeout expiry in the same cycle: the byte wins and the counter clears.
REQ-025 Output registers change only together with start; they hold all other values between start pulses.
REQ-026 Latency: start is asserted exactly 1 cycle after the checksum byte is accepted when engine_busy=0.
REQ-027 start and frame_err are never high in the same cycle.

Reset
REQ-028 While rst=1: state=IDLE, byte index=0, XOR=0, gap counter=0, start=0, frame_err=0, busy=0.
REQ-029 Reset values: pix_x=8'hFF, pix_y=8'hFF, cxs=16'hE000 (-2.0), cys=16'hF000 (-1.0), dcx=16'h0020, dcy=16'h0020.
REQ-030 Reset mid-frame discards the partial frame without pulsing frame_err; the registered r_ready is cleared so a byte held high across reset release is accepted once.

Structure
REQ-031 A shared package holds: the Q4.12 widths BIT_INT=4, BIT_FRAC=12, N_BIT=16; the reset-default constants; the state encoding.
REQ-032 One sub-module, mandel_byte_edge, holds the r_ready registration and the accept-pulse generation.

Verification
REQ-033 Frame A5, 80, 40, E0, 00, F0, 00, 00, 20, 00, 20 plus correct checksum, engine_busy=0 -> start 1 cycle after the checksum byte; pix_x=0x80, pix_y=0x40, cxs=E000, cys=F000, dcx=dcy=0020.
REQ-034 Same frame with the checksum XORed with 0x01 -> frame_err pulse; outputs keep their previous values; no start.
REQ-035 Sync byte, then 4 payload bytes, then a 70000-cycle idle gap -> frame_err at the timeout; the next full valid frame is accepted normally.
REQ-036 Valid frame with engine_busy=1 for 500 cycles, plus one extra byte sent meanwhile -> one frame_err for the extra byte; start in the cycle after engine_busy falls, with the new values.
REQ-037 r_ready held high for 20 cycles on byte 0xA5, then payload bytes -> only one accept; assert rst during byte 6 -> IDLE, reset defaults, no frame_err.
